// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the memory macro.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req0;
  logic          i_req1;
  logic          i_we0;
  logic          i_we1;
  logic [AW-1:0] i_addr0;
  logic [AW-1:0] i_addr1;
  logic [DW-1:0] i_wdata0;
  logic [DW-1:0] i_wdata1;
  logic          o_gnt0;
  logic          o_gnt1;
  logic          o_done0;
  logic          o_done1;
  logic [DW-1:0] o_rdata0;
  logic [DW-1:0] o_rdata1;
  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;
  logic          o_busy;

  modport slave (
    input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
    output o_gnt0, o_gnt1, o_done0, o_done1, o_rdata0, o_rdata1,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
  );

  modport master (
    output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
    input  o_gnt0, o_gnt1, o_done0, o_done1, o_rdata0, o_rdata1,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU = port 0, loader = port 1) for the shared single-port MIPS memory.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default build is fixed priority to port 0.
//
// state | meaning
// IDLE  | arbitrate, grant and capture one request
// ISSUE | one-cycle memory strobe with the captured command
// WAIT  | read latency down-counter running, capture read data at terminal count
// DONE  | completion pulse to the winning port
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic          port_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          any_req;
  logic          win;
  logic          grant;
  logic          rd_cap;

  assign any_req = bus.i_req0 | bus.i_req1;
  assign grant   = (state_q == IDLE) & any_req & ~i_reset;
  assign rd_cap  = (state_q == WAIT) & (cnt_q == '0);

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // On a tie the port not granted last wins; reset value makes port 0 win the first tie.
  always_comb begin
    win = bus.i_req1 & ~bus.i_req0;
    if (bus.i_req0 && bus.i_req1) win = ~last_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)    last_q <= 1'b1;
    else if (grant) last_q <= win;
  end
`else
  always_comb begin
    win = bus.i_req1 & ~bus.i_req0;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = ISSUE;
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      port_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        port_q  <= win;
        we_q    <= win ? bus.i_we1    : bus.i_we0;
        addr_q  <= win ? bus.i_addr1  : bus.i_addr0;
        wdata_q <= win ? bus.i_wdata1 : bus.i_wdata0;
      end
      if (rd_cap) begin
        if (port_q) rdata1_q <= bus.i_mem_rdata;
        else        rdata0_q <= bus.i_mem_rdata;
      end
    end
  end

  // Strobes are masked during reset so an aborted transaction never completes or touches memory.
  assign bus.o_gnt0      = grant & ~win;
  assign bus.o_gnt1      = grant & win;
  assign bus.o_done0     = (state_q == DONE) & ~port_q & ~i_reset;
  assign bus.o_done1     = (state_q == DONE) & port_q & ~i_reset;
  assign bus.o_mem_en    = (state_q == ISSUE) & ~i_reset;
  assign bus.o_mem_we    = (state_q == ISSUE) & we_q & ~i_reset;
  assign bus.o_busy      = (state_q != IDLE) & ~i_reset;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_rdata0    = rdata0_q;
  assign bus.o_rdata1    = rdata1_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port unified instruction/data memory of the multicycle MIPS core between the CPU (port 0) and the program loader / debug port (port 1). It accepts one transaction at a time, sequences the memory enable, write-enable, address and data through a fixed-latency access, and returns read data and a completion pulse to the winning requester. It sits between the CPU memory interface (IorD-muxed address) and the memory macro.

## Interface
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, memory read latency in cycles from the o_mem_en cycle to valid i_mem_rdata; legal range 1..15

- i_clk  in  1  clock
- i_reset  in  1  reset i_reset, synchronous, active-high; clock i_clk
- i_req0 / i_req1  in  1  transaction request, port 0 (CPU) / port 1 (loader)
- i_we0 / i_we1  in  1  1 = write, 0 = read
- i_addr0 / i_addr1  in  AW  byte address
- i_wdata0 / i_wdata1  in  DW  write data
- o_gnt0 / o_gnt1  out  1  one-cycle pulse: request accepted and captured this cycle
- o_done0 / o_done1  out  1  one-cycle pulse: transaction complete
- o_rdata0 / o_rdata1  out  DW  read data, valid from the o_done cycle, held until the next read completion on that port
- o_mem_en  out  1  memory access strobe
- o_mem_we  out  1  memory write enable (qualified by o_mem_en)
- o_mem_addr  out  AW  memory address
- o_mem_wdata  out  DW  memory write data
- i_mem_rdata  in  DW  memory read data
- o_busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any i_reqN is high, select a winner; assert o_gntN combinationally in the same cycle; capture we/addr/wdata and the port id at the clock edge; next state is ISSUE. With no request, stay in IDLE.
- ISSUE: drive o_mem_en=1, o_mem_we=captured we, o_mem_addr/o_mem_wdata from the captured registers for exactly one cycle. For a write, next state is DONE. For a read, load the latency counter with MEM_LAT-1; next state is WAIT.
- WAIT: the counter decrements each cycle. When the counter reaches 0, capture i_mem_rdata into the winning port's o_rdata register; next state is DONE.
- DONE: pulse o_doneN for the winning port; next state is IDLE.
- Outside ISSUE: o_mem_en=0 and o_mem_we=0. o_mem_addr and o_mem_wdata hold their captured values.
- After o_gntN, the requester may drop i_reqN. If i_reqN is still high in the IDLE cycle after DONE, it counts as a new request.
- Arbitration (see Configuration): a last-granted pointer is updated on every grant.
- A write never modifies o_rdataN.

## Timing
- Reset: state=IDLE. All of o_gnt*, o_done*, o_mem_en, o_mem_we and o_busy are 0. o_mem_addr, o_mem_wdata and o_rdata* are 0. The round-robin pointer is set so port 0 wins the first tie.
- Grant in cycle G:
  - Write: ISSUE at G+1; o_done at G+2.
  - Read: ISSUE at G+1; WAIT from G+2 to G+1+MEM_LAT; o_done and valid o_rdata at G+2+MEM_LAT.
- Minimum spacing between grants: write 3 cycles, read 3+MEM_LAT cycles. A request arriving while busy waits in IDLE arbitration. There is no queueing.
- Both requests in the same IDLE cycle: exactly one grant is issued. The loser keeps i_req high and is granted on the next IDLE cycle.
- Reset mid-transaction: the next cycle is IDLE, o_mem_en=0, and no o_done is issued for the aborted transaction.
- Requests asserted during reset are ignored. They are granted in the first IDLE cycle after reset if still high.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On a tie, the port that was not granted last wins.
- MEM_ARB_RR_EN undefined: fixed priority. Port 0 always wins a tie, and the pointer logic is not built. Port 1 can starve under continuous port-0 requests, which is acceptable when the loader runs only while the CPU is held.

## Test plan
- Single port-0 read, MEM_LAT=1, memory holds 0x8C020004 at 0x00: req at cycle 0 -> o_gnt0 at 0, o_mem_en at 1, o_done0 at 3, o_rdata0=0x8C020004.
- Single port-1 write of 0xDEADBEEF to 0x40: o_gnt1 at 0, o_mem_en=o_mem_we=1 with addr 0x40 at 1, o_done1 at 2; a subsequent read of 0x40 returns 0xDEADBEEF; o_rdata1 unchanged by the write.
- Both ports requesting continuously, writes: with MEM_ARB_RR_EN, grants alternate 0,1,0,1 every 3 cycles; without it, port 0 receives every grant.
- MEM_LAT=4 read: o_done exactly 6 cycles after grant; o_mem_en high for exactly 1 cycle; o_busy high for 6 cycles.
- Reset asserted in WAIT: next cycle is IDLE, o_busy=0, and no o_done is issued. A held request is granted in the first cycle after reset deasserts.
